// File: rtl/vec_chunk_buffer_pkg.sv
// Shared types and sizing helpers for the ping-pong vector chunk buffer.
// Bank occupancy states and the chunk-count calculation live here.
package vec_chunk_buffer_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Number of WorkingRegs-wide chunks needed to hold a vector (rounded up).
  function automatic int calc_chunks(input int vec_len, input int regs);
    return (vec_len + regs - 1) / regs;
  endfunction

endpackage

// File: rtl/vec_bank.sv
// One vector bank: flip-flop array of Chunks x WorkingRegs bytes with a
// byte-granular write port and a combinational whole-chunk read port.
module vec_bank #(
  parameter int WorkingRegs = 4,
  parameter int Chunks      = 2,
  parameter int CW          = 1,
  parameter int LW          = 2
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic                        clr,
  input  logic [CW-1:0]               wr_chunk,
  input  logic [LW-1:0]               wr_lane,
  input  logic [7:0]                  wr_byte,
  input  logic [CW-1:0]               rd_chunk,
  output logic [WorkingRegs-1:0][7:0] rd_data
);

  logic [WorkingRegs-1:0][7:0] mem_q [Chunks];

  // Clearing the last chunk zeroes its pad lanes; the write then lands on top.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q[Chunks-1] <= '0;
    end
    if (we) begin
      mem_q[wr_chunk][wr_lane] <= wr_byte;
    end
  end

  assign rd_data = mem_q[rd_chunk];

endmodule

// File: rtl/vec_chunk_buffer.sv
// Double-buffered vector store between two matrix-vector stages: elements are
// written one at a time into one bank while the other is read chunk by chunk.
module vec_chunk_buffer
  import vec_chunk_buffer_pkg::*;
#(
  parameter int VecLength   = 8,
  parameter int WorkingRegs = 4,
  parameter int ApplyRelu   = 1
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               wr_en,
  input  logic signed [7:0]                  wr_data,
  output logic                               wr_ready,
  input  logic                               rd_chunk_req,
  input  logic                               rd_ptr_rst,
  input  logic                               rd_release,
  output logic                               out_data_ready,
  output logic signed [WorkingRegs-1:0][7:0] out_data,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int Chunks = calc_chunks(VecLength, WorkingRegs);
  localparam int EW     = (VecLength > 1) ? $clog2(VecLength) : 1;
  localparam int CW     = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam int LW     = (WorkingRegs > 1) ? $clog2(WorkingRegs) : 1;

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [EW-1:0] elem_q, elem_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic [WorkingRegs-1:0][7:0] out_q, out_d;

  logic          wr_accept;
  logic          first_write;
  logic          last_elem;
  logic [CW-1:0] wr_chunk;
  logic [LW-1:0] wr_lane;
  logic [7:0]    store_byte;
  logic [WorkingRegs-1:0][7:0] bank_rd [2];

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bank_q[0]   <= BANK_EMPTY;
      bank_q[1]   <= BANK_EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      elem_q      <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      out_q       <= '0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      elem_q      <= elem_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      out_q       <= out_d;
    end
  end

  // Output / decode logic, all from pre-edge state.
  always_comb begin
    wr_ready       = (bank_q[wr_bank_q] != BANK_FULL);
    out_data_ready = (bank_q[rd_bank_q] == BANK_FULL);
    wr_accept      = wr_en && wr_ready;
    first_write    = (bank_q[wr_bank_q] == BANK_EMPTY);
    last_elem      = (elem_q == EW'(VecLength - 1));
    wr_chunk       = CW'(int'(elem_q) / WorkingRegs);
    wr_lane        = LW'(int'(elem_q) % WorkingRegs);
    store_byte     = (ApplyRelu != 0 && wr_data[7]) ? 8'd0 : wr_data;
  end

  // Next-state logic: write side and read side touch different banks.
  always_comb begin
    bank_d[0]   = bank_q[0];
    bank_d[1]   = bank_q[1];
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    elem_d      = elem_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q | (wr_en & ~wr_ready);
    underflow_d = underflow_q | (rd_chunk_req & ~out_data_ready);
    if (wr_accept) begin
      if (last_elem) begin
        bank_d[wr_bank_q] = BANK_FULL;
        elem_d            = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = BANK_FILLING;
        elem_d            = elem_q + 1'b1;
      end
    end
    if (rd_release && out_data_ready) begin
      bank_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d         = ~rd_bank_q;
      rd_ptr_d          = '0;
    end else if (rd_ptr_rst) begin
      rd_ptr_d = '0;
    end else if (rd_chunk_req && out_data_ready) begin
      rd_ptr_d = (rd_ptr_q == CW'(Chunks - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    vec_bank #(
      .WorkingRegs(WorkingRegs),
      .Chunks     (Chunks),
      .CW         (CW),
      .LW         (LW)
    ) u_bank (
      .clk     (clk_in),
      .we      (wr_accept && (int'(wr_bank_q) == b)),
      .clr     (wr_accept && first_write && (int'(wr_bank_q) == b)),
      .wr_chunk(wr_chunk),
      .wr_lane (wr_lane),
      .wr_byte (store_byte),
      .rd_chunk(rd_ptr_d),
      .rd_data (bank_rd[b])
    );
  end

  // Forward the byte written at this edge so a chunk completed by the final
  // write is already correct on out_data when out_data_ready rises.
  always_comb begin
    out_d = bank_rd[rd_bank_d];
    if (wr_accept && (wr_bank_q == rd_bank_d)) begin
      if (first_write && (rd_ptr_d == CW'(Chunks - 1))) begin
        out_d = '0;
      end
      if (wr_chunk == rd_ptr_d) begin
        out_d[wr_lane] = store_byte;
      end
    end
  end

  assign out_data  = out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
